// File: rtl/prehisle_pkg.sv
// Shared definitions for the 68K -> Z80 sound-latch bridge.
//   - m68k_state_e   : 68K bus-cycle FSM states
//   - DTACK_DELAY_DEFAULT : default strobe-to-DTACK latency in clocks
//   - is_latch_write : decodes a 68K byte write to the latch
package prehisle_pkg;

  localparam int unsigned LATCH_W             = 8;
  localparam int unsigned DTACK_CNT_W         = 4;
  localparam int unsigned DTACK_DELAY_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } m68k_state_e;

  // A latch write needs the select, a write cycle and the lower byte strobe.
  function automatic logic is_latch_write(input logic cs, input logic rw, input logic lds_n);
    return cs & ~rw & ~lds_n;
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// Registered rise/fall detector for a level strobe.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   strobe_i   : level to watch
//   rise_c_o   : strobe is high now and was low last clock
//   fall_c_o   : strobe is low now and was high last clock
module strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic prev_q;

  // One-clock history of the strobe; cleared on reset so no false edge follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= strobe_i;
    end
  end

  assign rise_c_o = strobe_i & ~prev_q;
  assign fall_c_o = ~strobe_i & prev_q;

endmodule

// File: rtl/sound_latch_bridge.sv
// 68K -> Z80 sound command latch with DTACK generation and NMI signalling.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   m68k_latch_cs  : 68K latch select (level, valid while AS low)
//   m68k_rw        : 68K R/W, 0 = write
//   m68k_lds_n     : 68K lower data strobe, active low
//   m68k_din       : 68K data bits 7:0
//   m68k_dtack_n   : DTACK for latch cycles, active low
//   z80_latch_cs   : Z80 latch select, MREQ qualified
//   z80_rd_n       : Z80 RD, active low
//   z80_dout       : latch contents toward the Z80 data mux
//   z80_nmi_n      : Z80 NMI request, active low
//   latch_pending  : unread command present
//   latch_overrun  : sticky, a write landed on an unread command
module sound_latch_bridge
  import prehisle_pkg::*;
#(
  parameter int unsigned DTACK_DELAY = DTACK_DELAY_DEFAULT,
  parameter int unsigned NMI_ENABLE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m68k_latch_cs,
  input  logic               m68k_rw,
  input  logic               m68k_lds_n,
  input  logic [LATCH_W-1:0] m68k_din,
  output logic               m68k_dtack_n,
  input  logic               z80_latch_cs,
  input  logic               z80_rd_n,
  output logic [LATCH_W-1:0] z80_dout,
  output logic               z80_nmi_n,
  output logic               latch_pending,
  output logic               latch_overrun
);

  localparam logic                   NMI_EN_B  = (NMI_ENABLE != 0);
  localparam logic [DTACK_CNT_W-1:0] WAIT_LOAD = DTACK_CNT_W'(DTACK_DELAY - 1);

  m68k_state_e            state_q;
  logic [DTACK_CNT_W-1:0] cnt_q;
  logic                   dtack_n_q;
  logic [LATCH_W-1:0]     latch_q;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   nmi_n_q;

  logic capture_c;
  logic z80_rd_c;
  logic rd_fall_c;
  logic unused_rd_rise;

  // A write is only accepted from IDLE; RELEASE blocks back-to-back strobes.
  assign capture_c = (state_q == ST_IDLE) &&
                     is_latch_write(m68k_latch_cs, m68k_rw, m68k_lds_n);

  assign z80_rd_c = z80_latch_cs & ~z80_rd_n;

  strobe_edge u_rd_edge (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (z80_rd_c),
    .rise_c_o (unused_rd_rise),
    .fall_c_o (rd_fall_c)
  );

  // 68K bus-cycle FSM with registered DTACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dtack_n_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dtack_n_q <= 1'b1;
          if (capture_c) begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          // An aborted cycle drops back without DTACK; the captured data stays.
          if (!m68k_latch_cs) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q   <= ST_ACK;
            dtack_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DTACK_CNT_W'(1);
          end
        end
        ST_ACK: begin
          if (!m68k_latch_cs) begin
            state_q   <= ST_RELEASE;
            dtack_n_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q   <= ST_IDLE;
          dtack_n_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_IDLE;
          dtack_n_q <= 1'b1;
        end
      endcase
    end
  end

  // Pending/overrun next state: capture beats a coincident end of Z80 read,
  // and a read ending on the capture clock means the old command was consumed.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (capture_c) begin
      pending_d = 1'b1;
      if (pending_q && !rd_fall_c) begin
        overrun_d = 1'b1;
      end
    end else if (rd_fall_c) begin
      pending_d = 1'b0;
    end
  end

  // Latch data, status flags and NMI.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      nmi_n_q   <= 1'b1;
    end else begin
      if (capture_c) begin
        latch_q <= m68k_din;
      end
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      nmi_n_q   <= ~(pending_d & NMI_EN_B);
    end
  end

  assign m68k_dtack_n  = dtack_n_q;
  assign z80_dout      = latch_q;
  assign z80_nmi_n     = nmi_n_q;
  assign latch_pending = pending_q;
  assign latch_overrun = overrun_q;

endmodule

// File: doc/sound_latch_bridge.md
SOUND_LATCH_BRIDGE -- requirements
Module: sound_latch_bridge

Interface
REQ-001 SHALL have parameter DTACK_DELAY, default 2, meaning clocks from accepted 68K strobe to DTACK assertion (range 1..15).
REQ-002 SHALL have parameter NMI_ENABLE, default 1, meaning drive z80_nmi_n from the pending flag; 0 holds z80_nmi_n high.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m68k_latch_cs  input  1  68K sound-latch select from the address decoder, level, valid while AS low.
REQ-007 m68k_rw  input  1  68K R/W; 0 = write.
REQ-008 m68k_lds_n  input  1  68K lower data strobe, active low.
REQ-009 m68k_din  input  8  68K data bus bits 7:0.
REQ-010 m68k_dtack_n  output  1  DTACK for latch cycles, active low.
REQ-011 z80_latch_cs  input  1  Z80 latch select, MREQ-qualified, level.
REQ-012 z80_rd_n  input  1  Z80 RD, active low.
REQ-013 z80_dout  output  8  latch contents toward Z80 data mux.
REQ-014 z80_nmi_n  output  1  Z80 NMI request, active low.
REQ-015 latch_pending  output  1  unread command present.
REQ-016 latch_overrun  output  1  sticky: write landed on unread command.

Function
REQ-017 68K FSM states: IDLE, WAIT, ACK, RELEASE.
REQ-018 IDLE -> WAIT when m68k_latch_cs & !m68k_rw & !m68k_lds_n are all true; data captured into latch register on that same edge.
REQ-019 WAIT counts DTACK_DELAY-1 further clocks then -> ACK; for DTACK_DELAY=1, WAIT lasts one clock.
REQ-020 ACK drives m68k_dtack_n low; holds until m68k_latch_cs falls -> RELEASE.
REQ-021 RELEASE drives m68k_dtack_n high for one clock -> IDLE; a new write is not accepted in RELEASE.
REQ-022 m68k_latch_cs deasserting in WAIT (aborted cycle) SHALL -> IDLE, captured data and pending set retained.
REQ-023 68K read cycles (m68k_rw=1) or m68k_lds_n high SHALL be ignored: FSM stays IDLE, no DTACK.
REQ-024 z80_dout SHALL equal the latch register, updated the clock after capture.
REQ-025 latch_pending SHALL set the clock after capture.
REQ-026 Z80 read = z80_latch_cs & !z80_rd_n; latch_pending SHALL clear on the clock the read strobe deasserts (falling edge of read term), never mid-read.
REQ-027 z80_nmi_n = !(latch_pending & NMI_ENABLE), registered.
REQ-028 Capture with latch_pending already 1 SHALL set latch_overrun and overwrite data; pending stays 1.
REQ-029 Capture and read-end on the same clock: capture wins; pending stays 1, no overrun, NMI stays low.
REQ-030 latch_overrun clears only on reset.

Reset
REQ-031 On reset: FSM IDLE, latch register 0x00, z80_dout 0x00, latch_pending 0, latch_overrun 0, m68k_dtack_n 1, z80_nmi_n 1, edge history cleared.
REQ-032 Reset mid-cycle SHALL abort immediately; a 68K strobe still held after reset is a new write only if cs, !rw, !lds_n are all still true in IDLE.

Structure
REQ-033 Shared package prehisle_pkg SHALL hold the FSM state enum and the DTACK_DELAY default constant.
REQ-034 One sub-module strobe_edge (registered rise/fall detector, reset to 0) SHALL be instanced for the Z80 read term.

Verification
REQ-035 Write 0x5A, DTACK_DELAY=2 -> dtack_n low 2 clocks after capture; z80_dout=0x5A; pending=1; nmi_n=0.
REQ-036 Z80 read strobe 3 clocks after pending -> pending and nmi_n unchanged during strobe, pending=0, nmi_n=1 the clock after strobe ends.
REQ-037 Writes 0x11 then 0x22 without read -> z80_dout=0x22, overrun=1, pending=1.
REQ-038 Read-end coincident with capture of 0x33 -> pending=1, overrun=0, z80_dout=0x33.
REQ-039 Reset asserted in ACK -> next clock dtack_n=1, pending=0, z80_dout=0x00; 68K read cycle afterwards -> no DTACK.
